// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM.
// Walks each instruction through fetch/decode/execute/memory/writeback, waits on the memory
// ready handshake under a watchdog, traps illegal opcodes and memory timeouts, and halts on syscall.
// Moore outputs are registered alongside the state; only ir_write/pc_write in FETCH and the
// store-completion retire follow mem_ready in the same cycle.
module multicycle_control #(
  parameter int         ALU_OP_W    = 6,
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [5:0] LUI_OP      = 6'h3F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic [4:0]          rt,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_byte,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [2:0]          branch_cond,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                retire,
  output logic                halted,
  output logic [1:0]          trap_cause
);

  typedef enum logic [3:0] {
    RESET_S  = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  EXEC_R = 4'd3,
    EXEC_I   = 4'd4,  MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WR = 4'd7,
    WB_ALU   = 4'd8,  WB_MEM = 4'd9,  BRANCH = 4'd10, JUMP   = 4'd11,
    HALT     = 4'd12
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_byte;
    logic       i_or_d;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] branch_cond;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_code;
    logic       retire;
    logic       halted;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_TMO  = 2'b10;
  localparam logic [1:0] CAUSE_SYS  = 2'b11;

  // Last wait count before the watchdog fires (count reaching MEM_TIMEOUT traps).
  localparam logic [7:0] WD_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;
  logic [4:0] rt_q, rt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] cause_q, cause_d;
  ctl_t       ctl_q, ctl_d;
  logic       fetch_done_s;

  // ALU code for immediate-form arithmetic/logic instructions.
  function automatic logic [5:0] imm_alu(input logic [5:0] op);
    logic [5:0] code;
    case (op)
      OP_ADDI:  code = ALU_ADD;
      OP_ADDIU: code = ALU_ADDU;
      OP_ANDI:  code = ALU_AND;
      OP_ORI:   code = ALU_OR;
      OP_XORI:  code = ALU_XOR;
      OP_SLTI:  code = ALU_SLT;
      OP_LUI:   code = LUI_OP;
      default:  code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Branch condition the datapath evaluates before loading the branch target.
  function automatic logic [2:0] br_cond(input logic [5:0] op, input logic [4:0] rt_v);
    logic [2:0] cond;
    case (op)
      OP_BEQ:    cond = 3'd1;
      OP_BNE:    cond = 3'd2;
      OP_BLEZ:   cond = 3'd3;
      OP_BGTZ:   cond = 3'd4;
      OP_REGIMM: cond = (rt_v == 5'd1) ? 3'd5 : 3'd6;
      default:   cond = 3'd0;
    endcase
    return cond;
  endfunction

  // Moore control word for a state, given the latched instruction fields.
  function automatic ctl_t decode_ctl(input state_t st, input logic [5:0] op,
                                      input logic [5:0] fn, input logic [4:0] rt_v);
    ctl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.mem_req = 1'b1; c.alu_src_b = 2'd1; c.alu_code = ALU_ADD;
      end
      DECODE: begin
        c.alu_src_b = 2'd3; c.alu_code = ALU_ADD;
      end
      EXEC_R: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd0; c.alu_code = fn;
      end
      EXEC_I: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_code = imm_alu(op);
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_code = ALU_ADD;
      end
      MEM_RD: begin
        c.mem_req = 1'b1; c.i_or_d = 1'b1; c.mem_byte = (op == OP_LB);
      end
      MEM_WR: begin
        c.mem_req = 1'b1; c.i_or_d = 1'b1; c.mem_we = 1'b1; c.mem_byte = (op == OP_SB);
      end
      WB_ALU: begin
        c.reg_write = 1'b1; c.reg_dst = (op == OP_RTYPE) ? 2'd1 : 2'd0; c.retire = 1'b1;
      end
      WB_MEM: begin
        c.reg_write = 1'b1; c.mem_to_reg = 2'd1; c.retire = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd0; c.alu_code = ALU_SUB;
        c.pc_src = 2'd1; c.branch_cond = br_cond(op, rt_v); c.retire = 1'b1;
      end
      JUMP: begin
        c.pc_write = 1'b1; c.pc_src = 2'd2; c.retire = 1'b1;
        c.reg_write  = (op == OP_JAL);
        c.reg_dst    = (op == OP_JAL) ? 2'd2 : 2'd0;
        c.mem_to_reg = (op == OP_JAL) ? 2'd2 : 2'd0;
      end
      HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Next state, instruction-field latch, watchdog and next control word.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    rt_d       = rt_q;
    cause_d    = cause_q;
    wait_cnt_d = 8'd0;
    case (state_q)
      RESET_S: state_d = FETCH;
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else if (wait_cnt_q == WD_LAST) begin
          state_d = HALT; cause_d = CAUSE_TMO;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      DECODE: begin
        op_d = opcode; funct_d = funct; rt_d = rt;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_SYSCALL) begin
              state_d = HALT; cause_d = CAUSE_SYS;
            end else begin
              state_d = EXEC_R;
            end
          end
          OP_J, OP_JAL:                      state_d = JUMP;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:  state_d = BRANCH;
          OP_REGIMM: begin
            if (rt == 5'd0 || rt == 5'd1) begin
              state_d = BRANCH;
            end else begin
              state_d = HALT; cause_d = CAUSE_ILL;
            end
          end
          OP_LW, OP_LB, OP_SW, OP_SB:        state_d = MEM_ADDR;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
          OP_XORI, OP_SLTI, OP_LUI:          state_d = EXEC_I;
          default: begin
            state_d = HALT; cause_d = CAUSE_ILL;
          end
        endcase
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      MEM_ADDR: state_d = (op_q == OP_SW || op_q == OP_SB) ? MEM_WR : MEM_RD;
      MEM_RD, MEM_WR: begin
        if (mem_ready) begin
          state_d = (state_q == MEM_RD) ? WB_MEM : FETCH;
        end else if (wait_cnt_q == WD_LAST) begin
          state_d = HALT; cause_d = CAUSE_TMO;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      WB_ALU, WB_MEM, BRANCH, JUMP: state_d = FETCH;
      HALT: state_d = HALT;
      default: begin
        state_d = RESET_S; cause_d = CAUSE_NONE;
      end
    endcase
    ctl_d = decode_ctl(state_d, op_d, funct_d, rt_d);
  end

  // FSM state, latched fields, watchdog and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_S;
      op_q       <= 6'd0;
      funct_q    <= 6'd0;
      rt_q       <= 5'd0;
      wait_cnt_q <= 8'd0;
      cause_q    <= CAUSE_NONE;
      ctl_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      funct_q    <= funct_d;
      rt_q       <= rt_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
      ctl_q      <= ctl_d;
    end
  end

  assign fetch_done_s = (state_q == FETCH) && mem_ready;

  assign mem_req     = ctl_q.mem_req;
  assign mem_we      = ctl_q.mem_we;
  assign mem_byte    = ctl_q.mem_byte;
  assign i_or_d      = ctl_q.i_or_d;
  assign ir_write    = fetch_done_s;
  assign pc_write    = ctl_q.pc_write | fetch_done_s;
  assign pc_src      = ctl_q.pc_src;
  assign branch_cond = ctl_q.branch_cond;
  assign reg_write   = ctl_q.reg_write;
  assign reg_dst     = ctl_q.reg_dst;
  assign mem_to_reg  = ctl_q.mem_to_reg;
  assign alu_src_a   = ctl_q.alu_src_a;
  assign alu_src_b   = ctl_q.alu_src_b;
  assign alu_op      = ALU_OP_W'(ctl_q.alu_code);
  assign retire      = ctl_q.retire | ((state_q == MEM_WR) && mem_ready);
  assign halted      = ctl_q.halted;
  assign trap_cause  = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: builds the expected per-cycle output sequence of each
// instruction from the instruction class and memory-wait counts, then checks every cycle.
`timescale 1ns/1ps
module tb_multicycle_control;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] opcode, funct;
  logic [4:0] rt;
  logic mem_ready;
  logic mem_req, mem_we, mem_byte, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src; logic [2:0] branch_cond; logic reg_write;
  logic [1:0] reg_dst, mem_to_reg; logic alu_src_a; logic [1:0] alu_src_b;
  logic [5:0] alu_op; logic retire, halted; logic [1:0] trap_cause;

  multicycle_control #(.ALU_OP_W(6), .MEM_TIMEOUT(TO), .LUI_OP(6'h3F)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rt(rt), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .branch_cond(branch_cond),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire),
    .halted(halted), .trap_cause(trap_cause));

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, mem_we, mem_byte, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src; logic [2:0] branch_cond; logic reg_write;
    logic [1:0] reg_dst, mem_to_reg; logic alu_src_a; logic [1:0] alu_src_b;
    logic [5:0] alu_op; logic retire, halted; logic [1:0] trap_cause;
  } outv_t;

  typedef struct packed {
    logic mr; logic [5:0] op; logic [5:0] fn; logic [4:0] rt; outv_t exp;
  } cyc_t;

  typedef enum int {C_R, C_SYS, C_I, C_LD, C_ST, C_BR, C_J, C_ILL} cls_t;

  localparam logic [5:0] G_OP = 6'h3F;   // junk driven outside DECODE
  localparam logic [5:0] G_FN = 6'h0C;
  localparam logic [4:0] G_RT = 5'h1F;

  outv_t act;
  assign act = {mem_req, mem_we, mem_byte, i_or_d, ir_write, pc_write, pc_src, branch_cond,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, retire,
                halted, trap_cause};

  cyc_t  sched[$];
  int    lats[$];
  int    errors = 0;
  int    checks = 0;
  outv_t exp_now;
  bit    exp_valid = 1'b0;
  string tag = "init";
  int    cyc_idx = 0;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Per-cycle comparison against the model sequence.
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_now) begin
        errors++;
        $display("FAIL %s[%0d]: got %h expected %h", tag, cyc_idx, act, exp_now);
      end
    end
  end

  // Instruction latency: cycles from first FETCH cycle through the retire pulse.
  int lat = 0;
  bit in_f = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      in_f = 1'b0; lat = 0;
    end else begin
      if (mem_req && !i_or_d && !in_f) lat = 1;
      else lat = lat + 1;
      in_f = mem_req && !i_or_d;
      if (retire) lats.push_back(lat);
    end
  end

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
    case (op)
      6'b000000: return (fn == 6'b001100) ? C_SYS : C_R;
      6'b000010, 6'b000011: return C_J;
      6'b000100, 6'b000101, 6'b000110, 6'b000111: return C_BR;
      6'b000001: return (r <= 5'd1) ? C_BR : C_ILL;
      6'b100011, 6'b100000: return C_LD;
      6'b101011, 6'b101000: return C_ST;
      6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001111: return C_I;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [5:0] imm_op(input logic [5:0] op);
    case (op)
      6'b001000: return 6'b100000;
      6'b001001: return 6'b100001;
      6'b001100: return 6'b100100;
      6'b001101: return 6'b100101;
      6'b001110: return 6'b100110;
      6'b001010: return 6'b101010;
      6'b001111: return 6'b111111;
      default:   return 6'b000000;
    endcase
  endfunction

  function automatic logic [2:0] cond_of(input logic [5:0] op, input logic [4:0] r);
    case (op)
      6'b000100: return 3'd1;
      6'b000101: return 3'd2;
      6'b000110: return 3'd3;
      6'b000111: return 3'd4;
      6'b000001: return (r == 5'd1) ? 3'd5 : 3'd6;
      default:   return 3'd0;
    endcase
  endfunction

  task automatic push(input logic mr, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] r, input outv_t e);
    cyc_t c;
    c.mr = mr; c.op = op; c.fn = fn; c.rt = r; c.exp = e;
    sched.push_back(c);
  endtask

  task automatic push_halt(input logic [1:0] cause, input int n);
    outv_t v;
    for (int i = 0; i < n; i++) begin
      v = '0; v.halted = 1'b1; v.trap_cause = cause;
      push(1'b1, G_OP, G_FN, G_RT, v);
    end
  endtask

  // Expected cycles of one instruction; fw/mw = wait cycles before mem_ready in fetch/data access.
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
                           input int fw, input int mw);
    outv_t v;
    cls_t  c;
    bit    st;
    for (int i = 0; i < fw && i < TO; i++) begin
      v = '0; v.mem_req = 1'b1; v.alu_src_b = 2'd1; v.alu_op = 6'b100000;
      push(1'b0, G_OP, G_FN, G_RT, v);
    end
    if (fw >= TO) begin
      push_halt(2'b10, 2);
      return;
    end
    v = '0; v.mem_req = 1'b1; v.alu_src_b = 2'd1; v.alu_op = 6'b100000;
    v.ir_write = 1'b1; v.pc_write = 1'b1;
    push(1'b1, G_OP, G_FN, G_RT, v);
    v = '0; v.alu_src_b = 2'd3; v.alu_op = 6'b100000;
    push(1'b1, op, fn, r, v);
    c = classify(op, fn, r);
    case (c)
      C_R, C_I: begin
        v = '0; v.alu_src_a = 1'b1;
        v.alu_src_b = (c == C_R) ? 2'd0 : 2'd2;
        v.alu_op    = (c == C_R) ? fn : imm_op(op);
        push(1'b1, G_OP, G_FN, G_RT, v);
        v = '0; v.reg_write = 1'b1; v.retire = 1'b1;
        v.reg_dst = (c == C_R) ? 2'd1 : 2'd0;
        push(1'b1, G_OP, G_FN, G_RT, v);
      end
      C_LD, C_ST: begin
        st = (c == C_ST);
        v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'd2; v.alu_op = 6'b100000;
        push(1'b1, G_OP, G_FN, G_RT, v);
        v = '0; v.mem_req = 1'b1; v.i_or_d = 1'b1; v.mem_we = st;
        v.mem_byte = (op == 6'b100000 || op == 6'b101000);
        for (int i = 0; i < mw && i < TO; i++) push(1'b0, G_OP, G_FN, G_RT, v);
        if (mw >= TO) begin
          push_halt(2'b10, 2);
          return;
        end
        v.retire = st;
        push(1'b1, G_OP, G_FN, G_RT, v);
        if (!st) begin
          v = '0; v.reg_write = 1'b1; v.mem_to_reg = 2'd1; v.retire = 1'b1;
          push(1'b1, G_OP, G_FN, G_RT, v);
        end
      end
      C_BR: begin
        v = '0; v.alu_src_a = 1'b1; v.alu_op = 6'b100010; v.pc_src = 2'd1;
        v.branch_cond = cond_of(op, r); v.retire = 1'b1;
        push(1'b1, G_OP, G_FN, G_RT, v);
      end
      C_J: begin
        v = '0; v.pc_write = 1'b1; v.pc_src = 2'd2; v.retire = 1'b1;
        if (op == 6'b000011) begin
          v.reg_write = 1'b1; v.reg_dst = 2'd2; v.mem_to_reg = 2'd2;
        end
        push(1'b1, G_OP, G_FN, G_RT, v);
      end
      C_SYS:   push_halt(2'b11, 3);
      default: push_halt(2'b01, 3);
    endcase
  endtask

  // Replay the first n scheduled cycles (all when n < 0) and discard the schedule.
  task automatic run_sched(input int n);
    int lim;
    lim = (n < 0 || n > sched.size()) ? sched.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      mem_ready = sched[i].mr; opcode = sched[i].op; funct = sched[i].fn; rt = sched[i].rt;
      exp_now = sched[i].exp; cyc_idx = i; exp_valid = 1'b1;
    end
    @(negedge clk); #1;
    exp_valid = 1'b0;
    sched.delete();
  endtask

  // Assert rst just after an edge, check outputs clear at once, release and see RESET_S.
  task automatic do_reset(input bit mid);
    @(posedge clk); #1;
    if (mid) check_val("pre_rst_mem_rd", {30'd0, mem_req, i_or_d}, 32'h3);
    rst = 1'b1; #1;
    check_val("rst_mem_req", {31'd0, mem_req}, 32'h0);
    check_val("rst_outs", {3'd0, act}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_state", {3'd0, act}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0; rt = 5'd0;
    do_reset(1'b0);

    tag = "basic";
    add_instr(6'b000000, 6'b100000, 5'd0, 0, 0);  // ADD
    add_instr(6'b001000, G_FN,      5'd0, 1, 0);  // ADDI, one fetch wait
    add_instr(6'b001111, G_FN,      5'd0, 0, 0);  // LUI
    add_instr(6'b100011, G_FN,      5'd0, 0, 3);  // LW, three data waits
    add_instr(6'b101000, G_FN,      5'd0, 0, 0);  // SB
    add_instr(6'b101011, G_FN,      5'd0, 0, 1);  // SW
    add_instr(6'b000100, G_FN,      5'd0, 0, 0);  // BEQ
    add_instr(6'b000001, G_FN,      5'd1, 0, 0);  // BGEZ
    add_instr(6'b000001, G_FN,      5'd0, 0, 0);  // BLTZ
    add_instr(6'b000011, G_FN,      5'd0, 0, 0);  // JAL
    add_instr(6'b000010, G_FN,      5'd0, 0, 0);  // J
    add_instr(6'b001010, G_FN,      5'd0, 0, 0);  // SLTI
    add_instr(6'b001101, G_FN,      5'd0, 0, 0);  // ORI
    add_instr(6'b000000, 6'b100010, 5'd0, 3, 0);  // SUB, fetch waits just under the limit
    add_instr(6'b100000, G_FN,      5'd0, 0, 0);  // LB
    add_instr(6'b000111, G_FN,      5'd0, 0, 2);  // BGTZ
    run_sched(-1);

    check_val("retire_count", lats.size(), 32'd16);
    check_val("lat_add",   lats[0], 32'd4);
    check_val("lat_addi",  lats[1], 32'd5);
    check_val("lat_lw_w3", lats[3], 32'd8);
    check_val("lat_sb",    lats[4], 32'd4);
    check_val("lat_bgez",  lats[7], 32'd3);
    check_val("lat_jal",   lats[9], 32'd3);
    check_val("lat_sub_f3", lats[13], 32'd7);
    lats.delete();

    tag = "illegal";
    add_instr(6'b111111, G_FN, 5'd0, 0, 0);
    run_sched(-1);
    check_val("ill_cause", {29'd0, halted, trap_cause}, 32'h5);
    do_reset(1'b0);

    tag = "syscall";
    add_instr(6'b000000, 6'b001100, 5'd0, 0, 0);
    run_sched(-1);
    check_val("sys_cause", {29'd0, halted, trap_cause}, 32'h7);
    do_reset(1'b0);

    tag = "regimm_bad";
    add_instr(6'b000001, G_FN, 5'd2, 0, 0);
    run_sched(-1);
    do_reset(1'b0);

    tag = "fetch_timeout";
    add_instr(6'b000000, 6'b100000, 5'd0, 4, 0);
    run_sched(-1);
    check_val("tmo_cause", {29'd0, halted, trap_cause}, 32'h6);
    do_reset(1'b0);

    tag = "rd_timeout";
    add_instr(6'b100011, G_FN, 5'd0, 0, 4);
    run_sched(-1);
    do_reset(1'b0);

    tag = "rst_mid_rd";
    add_instr(6'b100011, G_FN, 5'd0, 0, 3);
    run_sched(5);               // FETCH, DECODE, MEM_ADDR, two MEM_RD waits
    do_reset(1'b1);
    tag = "after_rst";
    add_instr(6'b000000, 6'b100000, 5'd0, 0, 0);
    run_sched(-1);
    check_val("post_rst_retires", lats.size(), 32'd1);
    check_val("post_rst_lat", lats[0], 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
